// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder/subtractor: FSM state
// encodings and the default operand width.
package serial_adder_pkg;

   localparam int unsigned DEF_WIDTH = 8;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      DONE = 2'b10
   } state_t;

endpackage : serial_adder_pkg

// File: rtl/full_adder_bit.sv
// One-bit combinational full adder used by the serial datapath.
// Ports:
//   a, b : operand bits
//   ci   : carry in
//   s    : sum bit
//   co   : carry out
module full_adder_bit (
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic s,
   output logic co
);

   assign s  = a ^ b ^ ci;
   assign co = (a & b) | (ci & (a ^ b));

endmodule : full_adder_bit

// File: rtl/serial_adder_fsm.sv
// Bit-serial adder/subtractor. One operand bit per cycle, LSB first,
// through a single full adder with a registered carry between bits.
// Ports:
//   CLK, NRST    : clock and asynchronous active-low reset
//   start        : launch an operation (accepted in IDLE or DONE)
//   rst          : synchronous abort, returns to IDLE and clears results
//   mode_sub     : 0 = A + B + CIN, 1 = A - B (CIN ignored)
//   CIN          : carry-in for add mode
//   A, B         : operands, sampled on the accepting edge
//   S, COUT, OVF : registered result, carry/not-borrow, signed overflow
//   busy         : high while the operation is in RUN
//   done         : one-cycle pulse when the result is loaded
module serial_adder_fsm
   import serial_adder_pkg::*;
#(
   parameter int unsigned WIDTH = DEF_WIDTH,
   parameter int unsigned CNT_W = $clog2(WIDTH)
) (
   input  logic             CLK,
   input  logic             NRST,
   input  logic             start,
   input  logic             rst,
   input  logic             mode_sub,
   input  logic             CIN,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic [WIDTH-1:0] S,
   output logic             COUT,
   output logic             OVF,
   output logic             busy,
   output logic             done
);

   state_t             state, state_nxt;
   logic [WIDTH-1:0]   a_q, a_nxt;
   logic [WIDTH-1:0]   b_q, b_nxt;
   logic [WIDTH-1:0]   sh_q, sh_nxt;
   logic [CNT_W-1:0]   cnt_q, cnt_nxt;
   logic               carry_q, carry_nxt;
   logic [WIDTH-1:0]   s_nxt;
   logic               cout_nxt, ovf_nxt, busy_nxt, done_nxt;
   logic               fa_s, fa_co;
   logic               last_bit_c;

   // Single bit slice; operands are shifted right so bit 0 is always current.
   full_adder_bit u_fa (
      .a  (a_q[0]),
      .b  (b_q[0]),
      .ci (carry_q),
      .s  (fa_s),
      .co (fa_co)
   );

   assign last_bit_c = (cnt_q == CNT_W'(WIDTH - 1));

   // State and datapath registers.
   always_ff @(posedge CLK or negedge NRST) begin
      if (!NRST) begin
         state   <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         sh_q    <= '0;
         cnt_q   <= '0;
         carry_q <= 1'b0;
         S       <= '0;
         COUT    <= 1'b0;
         OVF     <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         state   <= state_nxt;
         a_q     <= a_nxt;
         b_q     <= b_nxt;
         sh_q    <= sh_nxt;
         cnt_q   <= cnt_nxt;
         carry_q <= carry_nxt;
         S       <= s_nxt;
         COUT    <= cout_nxt;
         OVF     <= ovf_nxt;
         busy    <= busy_nxt;
         done    <= done_nxt;
      end
   end

   // Next-state and datapath next values.
   always_comb begin
      state_nxt = state;
      a_nxt     = a_q;
      b_nxt     = b_q;
      sh_nxt    = sh_q;
      cnt_nxt   = cnt_q;
      carry_nxt = carry_q;
      s_nxt     = S;
      cout_nxt  = COUT;
      ovf_nxt   = OVF;

      if (rst) begin
         state_nxt = IDLE;
         a_nxt     = '0;
         b_nxt     = '0;
         sh_nxt    = '0;
         cnt_nxt   = '0;
         carry_nxt = 1'b0;
         s_nxt     = '0;
         cout_nxt  = 1'b0;
         ovf_nxt   = 1'b0;
      end else begin
         unique case (state)
            IDLE, DONE: begin
               if (start) begin
                  // Subtraction is A + ~B + 1.
                  state_nxt = RUN;
                  a_nxt     = A;
                  b_nxt     = mode_sub ? ~B : B;
                  carry_nxt = mode_sub ? 1'b1 : CIN;
                  cnt_nxt   = '0;
               end else begin
                  state_nxt = IDLE;
               end
            end
            RUN: begin
               a_nxt     = {1'b0, a_q[WIDTH-1:1]};
               b_nxt     = {1'b0, b_q[WIDTH-1:1]};
               sh_nxt    = {fa_s, sh_q[WIDTH-1:1]};
               carry_nxt = fa_co;
               cnt_nxt   = cnt_q + CNT_W'(1);
               if (last_bit_c) begin
                  // carry_q is the carry into the MSB, fa_co the carry out.
                  state_nxt = DONE;
                  cnt_nxt   = '0;
                  s_nxt     = {fa_s, sh_q[WIDTH-1:1]};
                  cout_nxt  = fa_co;
                  ovf_nxt   = carry_q ^ fa_co;
               end
            end
            default: state_nxt = IDLE;
         endcase
      end

      busy_nxt = (state_nxt == RUN);
      done_nxt = (state_nxt == DONE);
   end

endmodule : serial_adder_fsm

// File: tb/tb_serial_adder_fsm.sv
// Self-checking bench for serial_adder_fsm (WIDTH=8): directed vectors,
// abort/reset cases and randomized operations against an arithmetic model.
module tb_serial_adder_fsm;

   localparam int unsigned W = 8;

   logic         CLK;
   logic         NRST;
   logic         start;
   logic         rst;
   logic         mode_sub;
   logic         CIN;
   logic [W-1:0] A;
   logic [W-1:0] B;
   logic [W-1:0] S;
   logic         COUT;
   logic         OVF;
   logic         busy;
   logic         done;

   int n_checks;
   int n_fail;

   // Last completed result expected on the outputs.
   logic [W-1:0] prev_s;
   logic         prev_cout;
   logic         prev_ovf;

   serial_adder_fsm #(.WIDTH(W)) dut (
      .CLK      (CLK),
      .NRST     (NRST),
      .start    (start),
      .rst      (rst),
      .mode_sub (mode_sub),
      .CIN      (CIN),
      .A        (A),
      .B        (B),
      .S        (S),
      .COUT     (COUT),
      .OVF      (OVF),
      .busy     (busy),
      .done     (done)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference: plain integer arithmetic on W+1 bits.
   task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                        input logic sub, output logic [W-1:0] s, output logic cout,
                        output logic ovf);
      logic [W-1:0] beff;
      logic [W:0]   sum;
      beff = sub ? ~b : b;
      sum  = {1'b0, a} + {1'b0, beff} + {{W{1'b0}}, (sub ? 1'b1 : cin)};
      s    = sum[W-1:0];
      cout = sum[W];
      ovf  = (a[W-1] == beff[W-1]) && (s[W-1] != a[W-1]);
   endtask

   // Called at a negedge: present operands with start, pass the accepting
   // edge, and check that the first RUN cycle shows busy.
   task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                         input logic sub);
      A        = a;
      B        = b;
      CIN      = cin;
      mode_sub = sub;
      start    = 1'b1;
      @(negedge CLK);
      start = 1'b0;
      check("run1_busy", 32'(busy), 32'd1);
      check("run1_done", 32'(done), 32'd0);
   endtask

   // Remaining RUN cycles then the DONE cycle; poke drives start and
   // scrambles operands during RUN, which must be ignored.
   task automatic finish(input string tag, input logic [W-1:0] es, input logic ec,
                         input logic eo, input bit poke);
      for (int i = 1; i < int'(W); i++) begin
         if (poke) begin
            start = (i < int'(W) - 1);
            A     = W'($urandom);
            B     = W'($urandom);
         end
         @(negedge CLK);
         check({tag, "_run_busy"}, 32'(busy), 32'd1);
         check({tag, "_run_hold_s"}, 32'(S), 32'(prev_s));
         check({tag, "_run_hold_f"}, 32'({COUT, OVF}), 32'({prev_cout, prev_ovf}));
      end
      start = 1'b0;
      @(negedge CLK);
      check({tag, "_done"}, 32'(done), 32'd1);
      check({tag, "_busy"}, 32'(busy), 32'd0);
      check({tag, "_s"}, 32'(S), 32'(es));
      check({tag, "_cout"}, 32'(COUT), 32'(ec));
      check({tag, "_ovf"}, 32'(OVF), 32'(eo));
      prev_s    = es;
      prev_cout = ec;
      prev_ovf  = eo;
   endtask

   task automatic expect_idle(input string tag);
      @(negedge CLK);
      check({tag, "_idle_done"}, 32'(done), 32'd0);
      check({tag, "_idle_busy"}, 32'(busy), 32'd0);
      check({tag, "_idle_s"}, 32'(S), 32'(prev_s));
   endtask

   task automatic full_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic cin, input logic sub);
      logic [W-1:0] es;
      logic         ec, eo;
      model(a, b, cin, sub, es, ec, eo);
      launch(a, b, cin, sub);
      finish(tag, es, ec, eo, 1'b0);
   endtask

   initial begin
      logic [W-1:0] ra, rb, es;
      logic         rc, rs, ec, eo;

      n_checks  = 0;
      n_fail    = 0;
      prev_s    = '0;
      prev_cout = 1'b0;
      prev_ovf  = 1'b0;
      NRST      = 1'b0;
      start     = 1'b0;
      rst       = 1'b0;
      mode_sub  = 1'b0;
      CIN       = 1'b0;
      A         = '0;
      B         = '0;

      // Reset values
      repeat (2) @(negedge CLK);
      check("rst_s", 32'(S), 32'd0);
      check("rst_flags", 32'({COUT, OVF, busy, done}), 32'd0);
      NRST = 1'b1;
      expect_idle("post_rst");

      // Directed vectors
      launch(8'h5A, 8'h3C, 1'b0, 1'b0);
      finish("add_5a_3c", 8'h96, 1'b0, 1'b1, 1'b0);
      expect_idle("add_5a_3c");
      full_op("add_ff_01", 8'hFF, 8'h01, 1'b0, 1'b0);
      check("add_ff_01_exp", 32'({S, COUT, OVF}), 32'({8'h00, 1'b1, 1'b0}));
      expect_idle("add_ff_01");
      full_op("add_ff_01_c1", 8'hFF, 8'h01, 1'b1, 1'b0);
      check("add_ff_01_c1_exp", 32'({S, COUT}), 32'({8'h01, 1'b1}));
      expect_idle("add_ff_01_c1");
      launch(8'h10, 8'h20, 1'b1, 1'b1);
      finish("sub_10_20", 8'hF0, 1'b0, 1'b0, 1'b1);
      expect_idle("sub_10_20");
      full_op("sub_ovf", 8'h80, 8'h01, 1'b0, 1'b1);
      expect_idle("sub_ovf");

      // Back-to-back: start held through DONE
      launch(8'h33, 8'h44, 1'b0, 1'b0);
      finish("b2b_first", 8'h77, 1'b0, 1'b0, 1'b0);
      launch(8'h01, 8'h01, 1'b0, 1'b0);
      finish("b2b_second", 8'h02, 1'b0, 1'b0, 1'b0);
      expect_idle("b2b");

      // Synchronous abort in the 3rd RUN cycle
      launch(8'h12, 8'h34, 1'b0, 1'b0);
      @(negedge CLK);
      @(negedge CLK);
      rst = 1'b1;
      @(negedge CLK);
      rst       = 1'b0;
      prev_s    = '0;
      prev_cout = 1'b0;
      prev_ovf  = 1'b0;
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_outs", 32'({S, COUT, OVF, done}), 32'd0);
      for (int i = 0; i < int'(W) + 2; i++) begin
         @(negedge CLK);
         check("abort_no_done", 32'({done, busy}), 32'd0);
      end

      // rst wins over start
      A     = 8'h11;
      B     = 8'h22;
      start = 1'b1;
      rst   = 1'b1;
      @(negedge CLK);
      start = 1'b0;
      rst   = 1'b0;
      check("rst_vs_start", 32'({busy, done}), 32'd0);

      // Asynchronous reset mid-RUN
      full_op("pre_nrst", 8'h0F, 8'h0F, 1'b0, 1'b0);
      expect_idle("pre_nrst");
      launch(8'h55, 8'h66, 1'b0, 1'b0);
      @(negedge CLK);
      #2 NRST = 1'b0;
      #1;
      check("nrst_async_s", 32'(S), 32'd0);
      check("nrst_async_flags", 32'({COUT, OVF, busy, done}), 32'd0);
      prev_s    = '0;
      prev_cout = 1'b0;
      prev_ovf  = 1'b0;
      @(negedge CLK);
      NRST = 1'b1;
      expect_idle("post_nrst");
      full_op("after_nrst", 8'h21, 8'h43, 1'b1, 1'b0);

      // Start ignored during RUN
      model(8'hC8, 8'h64, 1'b0, 1'b1, es, ec, eo);
      launch(8'hC8, 8'h64, 1'b0, 1'b1);
      finish("start_in_run", es, ec, eo, 1'b1);
      expect_idle("start_in_run");

      // Randomized operations, sometimes back-to-back
      for (int n = 0; n < 24; n++) begin
         ra = W'($urandom);
         rb = W'($urandom);
         rc = 1'($urandom);
         rs = 1'($urandom);
         full_op("rand", ra, rb, rc, rs);
         if ($urandom_range(1) == 0) expect_idle("rand");
      end
      expect_idle("final");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_serial_adder_fsm

// File: doc/serial_adder_fsm.md
SERIAL_ADDER_FSM -- requirements
Module: serial_adder_fsm

Interface
REQ-001 Parameter WIDTH, default 8, operand/result width in bits; the block SHALL support any WIDTH >= 2.
REQ-002 Parameter CNT_W, default $clog2(WIDTH), width of the bit counter; the block SHALL size the counter so that it holds values 0..WIDTH-1.
REQ-003 CLK  input  1  single clock; the block SHALL update all state on its rising edge only.
REQ-004 NRST  input  1  reset; the block SHALL treat it as asynchronous and active-low.
REQ-005 start  input  1  the block SHALL accept a new operation when start is high in IDLE or DONE.
REQ-006 rst  input  1  synchronous abort, active-high; the block SHALL abort any operation on it.
REQ-007 mode_sub  input  1  the block SHALL add when 0 and subtract when 1; it SHALL sample mode_sub with start.
REQ-008 CIN  input  1  carry-in; the block SHALL use it in add mode only.
REQ-009 A, B  input  WIDTH  operands; the block SHALL sample them on the accepting edge.
REQ-010 S  output  WIDTH  registered result word.
REQ-011 COUT  output  1  registered carry-out (add) or not-borrow (sub).
REQ-012 OVF  output  1  registered signed-overflow flag.
REQ-013 busy  output  1  the block SHALL drive busy high while in RUN.
REQ-014 done  output  1  the block SHALL drive done high for exactly one cycle, in DONE.

Function
REQ-015 The FSM SHALL have exactly the states IDLE, RUN and DONE.
REQ-016 In IDLE with start=1 and rst=0, the block SHALL capture A, ~B or B, and the carry-in, clear the counter to 0, and go to RUN on the next edge.
REQ-017 In subtract mode the block SHALL use B_eff = ~B and carry-in = 1, ignoring CIN; in add mode it SHALL use B_eff = B and carry-in = CIN.
REQ-018 In RUN the block SHALL process one bit per cycle, LSB first, via one full-adder bit, with the carry held in a 1-bit register between bits.
REQ-019 In RUN the block SHALL shift each sum bit into the result register from the MSB side.
REQ-020 The block SHALL stay in RUN for exactly WIDTH cycles and go to DONE on the edge that processes bit WIDTH-1.
REQ-021 On that edge the block SHALL load S with the full sum, COUT with the final carry, and OVF with (carry into MSB) XOR (carry out of MSB).
REQ-022 Latency: with start accepted at edge k, done SHALL be high during the cycle following edge k+WIDTH.
REQ-023 In DONE with start=1 the block SHALL accept a new operation directly (DONE->RUN, back-to-back); otherwise it SHALL go DONE->IDLE.
REQ-024 The block SHALL ignore start while in RUN.
REQ-025 S, COUT and OVF SHALL hold their last completed values while in IDLE and RUN until the next operation completes.
REQ-026 rst=1 in any state SHALL force IDLE on the next edge and clear S, COUT, OVF, the carry and the counter to 0; done SHALL NOT be asserted for the aborted operation.
REQ-027 If rst and start are both high together, rst SHALL win and the block SHALL stay in or return to IDLE.
REQ-028 The FSM SHALL return any unreachable state encoding to IDLE on the next edge.

Reset
REQ-029 NRST low SHALL asynchronously force: state=IDLE, S=0, COUT=0, OVF=0, busy=0, done=0, counter=0, carry=0, operand registers=0.
REQ-030 Asserting NRST mid-RUN SHALL discard the operation; after release the block SHALL wait in IDLE for start.
REQ-031 The block SHALL have no negative-edge or level-sensitive storage.

Structure
REQ-032 Package serial_adder_pkg SHALL hold the state encodings (IDLE=2'b00, RUN=2'b01, DONE=2'b10) and the default WIDTH.
REQ-033 Sub-module full_adder_bit SHALL implement the combinational one-bit sum/carry (inputs a, b, ci; outputs s, co) and SHALL be instantiated once.

Verification (WIDTH=8)
REQ-034 A=8'h5A, B=8'h3C, CIN=0, add, start -> after 8 RUN cycles: done pulse, S=8'h96, COUT=0, OVF=1.
REQ-035 A=8'hFF, B=8'h01, CIN=0, add -> S=8'h00, COUT=1, OVF=0; with CIN=1 -> S=8'h01, COUT=1.
REQ-036 A=8'h10, B=8'h20, subtract, CIN=1 -> S=8'hF0, COUT=0, OVF=0 (CIN ignored).
REQ-037 Start, then rst=1 in the 3rd RUN cycle -> IDLE next edge, busy=0, S=0, COUT=0, OVF=0, no done.
REQ-038 start held high through DONE with new operands 8'h01+8'h01 -> RUN with no idle cycle; busy low only during the DONE cycle; second result S=8'h02.
REQ-039 NRST pulsed low mid-RUN -> all outputs 0 immediately; start after release -> correct result 8 cycles later.
